// File: rtl/adder_arbiter.sv
// Two-requester adder: A and B share one W-bit adder through a round-robin grant and
// feed a single-entry result register with valid/ready handshakes on every side.
module adder_arbiter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         a_valid_i,
    input  logic [W-1:0] a_op0_i,
    input  logic [W-1:0] a_op1_i,
    output logic         a_ready_o,
    input  logic         b_valid_i,
    input  logic [W-1:0] b_op0_i,
    input  logic [W-1:0] b_op1_i,
    output logic         b_ready_o,
    output logic         res_valid_o,
    input  logic         res_ready_i,
    output logic [W-1:0] res_sum_o,
    output logic         res_carry_o,
    output logic         res_id_o,
    output logic [3:0]   ovf_cnt_o
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e       state_q, state_d;
    logic [W-1:0] sum_q, sum_d;
    logic         carry_q, carry_d;
    logic         id_q, id_d;
    logic [3:0]   ovf_q, ovf_d;
    logic         last_id_q, last_id_d;

    logic         slot_free;
    logic         grant_a;
    logic         grant_b;
    logic         accept;
    logic [W-1:0] op0;
    logic [W-1:0] op1;
    logic [W:0]   add_full;

    // A ready slot may be reused in the same cycle the consumer drains it.
    assign slot_free = (state_q == StEmpty) || res_ready_i;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst && slot_free) begin
            if (a_valid_i && b_valid_i) begin
                // On a tie, favour whoever was not served last.
                grant_b = (last_id_q == 1'b0);
                grant_a = (last_id_q == 1'b1);
            end else begin
                grant_a = a_valid_i;
                grant_b = b_valid_i;
            end
        end
    end

    assign a_ready_o = grant_a;
    assign b_ready_o = grant_b;
    assign accept    = grant_a | grant_b;

    assign op0      = grant_b ? b_op0_i : a_op0_i;
    assign op1      = grant_b ? b_op1_i : a_op1_i;
    assign add_full = {1'b0, op0} + {1'b0, op1};

    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        id_d      = id_q;
        ovf_d     = ovf_q;
        last_id_d = last_id_q;
        if (accept) begin
            state_d   = StFull;
            sum_d     = add_full[W-1:0];
            carry_d   = add_full[W];
            id_d      = grant_b;
            last_id_d = grant_b;
            if (add_full[W] && (ovf_q != 4'hF)) begin
                ovf_d = ovf_q + 4'd1;
            end
        end else if ((state_q == StFull) && res_ready_i) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StEmpty;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            id_q      <= 1'b0;
            ovf_q     <= 4'd0;
            last_id_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            id_q      <= id_d;
            ovf_q     <= ovf_d;
            last_id_q <= last_id_d;
        end
    end

    assign res_valid_o = (state_q == StFull);
    assign res_sum_o   = sum_q;
    assign res_carry_o = carry_q;
    assign res_id_o    = id_q;
    assign ovf_cnt_o   = ovf_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: single request, tie alternation, backpressure,
// carry/saturation and asynchronous reset in mid-flight.
module tb_adder_arbiter;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         a_valid;
    logic [W-1:0] a_op0;
    logic [W-1:0] a_op1;
    logic         a_ready;
    logic         b_valid;
    logic [W-1:0] b_op0;
    logic [W-1:0] b_op1;
    logic         b_ready;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_sum;
    logic         res_carry;
    logic         res_id;
    logic [3:0]   ovf_cnt;

    int unsigned n_chk;
    int unsigned n_pass;

    adder_arbiter #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .a_valid_i   (a_valid),
        .a_op0_i     (a_op0),
        .a_op1_i     (a_op1),
        .a_ready_o   (a_ready),
        .b_valid_i   (b_valid),
        .b_op0_i     (b_op0),
        .b_op1_i     (b_op1),
        .b_ready_o   (b_ready),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_sum_o   (res_sum),
        .res_carry_o (res_carry),
        .res_id_o    (res_id),
        .ovf_cnt_o   (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        rst       = 1'b1;
        a_valid   = 1'b1;
        a_op0     = 8'h12;
        a_op1     = 8'h34;
        b_valid   = 1'b1;
        b_op0     = '0;
        b_op1     = '0;
        res_ready = 1'b1;
        #12;

        // Reset state, with both requesters already asserting valid.
        check("rst_res_valid", res_valid, 0);
        check("rst_res_sum",   res_sum,   0);
        check("rst_carry",     res_carry, 0);
        check("rst_id",        res_id,    0);
        check("rst_ovf",       ovf_cnt,   0);
        check("rst_a_ready",   a_ready,   0);
        check("rst_b_ready",   b_ready,   0);

        // Single A request.
        b_valid = 1'b0;
        rst     = 1'b0;
        #1;
        check("single_a_ready", a_ready, 1);
        check("single_b_ready", b_ready, 0);
        tick();
        a_valid = 1'b0;
        check("single_valid", res_valid, 1);
        check("single_sum",   res_sum,   8'h46);
        check("single_carry", res_carry, 0);
        check("single_id",    res_id,    0);
        tick();
        check("drain_valid", res_valid, 0);

        // Fresh reset, then continuous tie: A,B,A,B.
        rst = 1'b1;
        #1;
        rst     = 1'b0;
        a_valid = 1'b1;
        a_op0   = 8'd1;
        a_op1   = 8'd2;
        b_valid = 1'b1;
        b_op0   = 8'd3;
        b_op1   = 8'd4;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("tie_a_ready", a_ready, (i % 2 == 0) ? 1 : 0);
            check("tie_b_ready", b_ready, (i % 2 == 0) ? 0 : 1);
            tick();
            check("tie_valid", res_valid, 1);
            check("tie_id",    res_id,    (i % 2 == 0) ? 0 : 1);
            check("tie_sum",   res_sum,   (i % 2 == 0) ? 8'd3 : 8'd7);
        end

        // Backpressure: B's result (7) held, B requests again.
        a_valid   = 1'b0;
        b_op0     = 8'h10;
        b_op1     = 8'h20;
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_b_ready", b_ready,   0);
            check("bp_valid",   res_valid, 1);
            check("bp_sum",     res_sum,   8'd7);
            check("bp_id",      res_id,    1);
            tick();
        end
        res_ready = 1'b1;
        #1;
        check("bp_release_b_ready", b_ready, 1);
        tick();
        b_valid = 1'b0;
        check("bp_new_valid", res_valid, 1);
        check("bp_new_sum",   res_sum,   8'h30);
        check("bp_new_id",    res_id,    1);

        // Carry and saturation of the overflow counter.
        a_valid = 1'b1;
        a_op0   = 8'hFF;
        a_op1   = 8'h01;
        for (int i = 0; i < 17; i++) begin
            tick();
            check("cy_sum",   res_sum,   8'h00);
            check("cy_carry", res_carry, 1);
            check("cy_ovf",   ovf_cnt,   (i + 1 > 15) ? 15 : i + 1);
        end

        // Asynchronous reset while a result is held.
        a_valid   = 1'b0;
        res_ready = 1'b0;
        tick();
        check("pre_rst_valid", res_valid, 1);
        rst     = 1'b1;
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_op0   = 8'h05;
        a_op1   = 8'h06;
        #1;
        check("mid_rst_valid",   res_valid, 0);
        check("mid_rst_ovf",     ovf_cnt,   0);
        check("mid_rst_sum",     res_sum,   0);
        check("mid_rst_carry",   res_carry, 0);
        check("mid_rst_a_ready", a_ready,   0);
        check("mid_rst_b_ready", b_ready,   0);
        rst = 1'b0;
        #1;
        check("post_rst_a_ready", a_ready, 1);
        check("post_rst_b_ready", b_ready, 0);
        tick();
        check("post_rst_id",  res_id,  0);
        check("post_rst_sum", res_sum, 8'h0B);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter: W, default 8, operand and sum width.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 a_valid  input  1  requester A has an operand pair.
REQ-005 a_op0, a_op1  input  W each  requester A operands.
REQ-006 a_ready  output  1  A's pair accepted this cycle when a_valid&a_ready.
REQ-007 b_valid, b_op0, b_op1, b_ready  same as REQ-004..006, for requester B.
REQ-008 res_valid  output  1  result register holds an unconsumed result.
REQ-009 res_ready  input  1  consumer takes result when res_valid&res_ready.
REQ-010 res_sum  output  W  (op0+op1) mod 2^W.
REQ-011 res_carry  output  1  carry-out of the W-bit add.
REQ-012 res_id  output  1  0 = result belongs to A, 1 = B.
REQ-013 ovf_cnt  output  4  saturating count of accepted adds with carry=1.

Function
REQ-014 Block SHALL own one W-bit adder and share it between A and B; at most one request accepted per cycle.
REQ-015 FSM states: EMPTY (no result held), FULL (result held); EMPTY->FULL on accept; FULL->EMPTY on res_ready with no accept same cycle; FULL->FULL on res_ready with accept same cycle, or on no res_ready.
REQ-016 Slot free SHALL be: state==EMPTY, or state==FULL and res_ready==1 (combinational pass-through of res_ready into a_ready/b_ready).
REQ-017 Grant: if slot free and exactly one valid, that requester's ready=1; if both valid, ready goes to the requester not accepted most recently (round-robin pointer last_id).
REQ-018 a_ready and b_ready SHALL never both be 1; ready SHALL be 0 for a requester whose valid is 0.
REQ-019 last_id SHALL update only on an accept, to the accepted requester's id; unchanged when idle or stalled.
REQ-020 Latency: pair accepted in cycle N SHALL appear on res_sum/res_carry/res_id with res_valid=1 from cycle N+1.
REQ-021 Result outputs SHALL hold stable while res_valid=1 and res_ready=0.
REQ-022 Sustained throughput one result per cycle when res_ready held 1 and requests available.
REQ-023 Sum computed on W+1 bits; res_sum = low W bits, res_carry = bit W; e.g. 0xFF+0x01 -> sum 0x00, carry 1.
REQ-024 ovf_cnt SHALL increment by 1 on each accept whose carry=1; saturate at 15; never wrap.
REQ-025 Requester not granted SHALL see ready=0 and is required to hold valid and operands; block SHALL not drop or reorder its request.

Reset
REQ-026 While rst=1, asynchronously: state=EMPTY, res_valid=0, res_sum=0, res_carry=0, res_id=0, ovf_cnt=0, last_id=1 (A wins first tie).
REQ-027 a_ready and b_ready SHALL be 0 while rst=1.
REQ-028 Reset asserted mid-transaction SHALL discard any held result; first cycle after release behaves as fresh EMPTY.

Verification
REQ-029 Single A: a_valid=1, a_op0=0x12, a_op1=0x34, res_ready=1 -> a_ready=1 cycle N; cycle N+1 res_valid=1, res_sum=0x46, carry=0, id=0.
REQ-030 Tie: A and B valid continuously, res_ready=1, after reset -> accepts alternate A,B,A,B; res_id sequence 0,1,0,1; one result per cycle.
REQ-031 Backpressure: result held, res_ready=0 for 3 cycles with B valid -> b_ready=0, res outputs stable; res_ready=1 -> B accepted same cycle, its result next cycle.
REQ-032 Carry/saturation: 17 accepts of 0xFF+0x01 -> each res_sum=0x00, carry=1; ovf_cnt reaches 15 and stays 15.
REQ-033 Reset mid-flight: rst=1 while res_valid=1 -> res_valid, ovf_cnt, outputs 0 immediately (before next edge); after release, tie grants A first.
